// File: rtl/bb_mem_arbiter.sv
// Two-master round-robin arbiter in front of one synchronous single-port memory.
// Optional `BB_ARB_LOCK_EN adds i_lock so the last winner can keep the memory.
//
// state | meaning
// IDLE  | sample requests, pick winner, launch access
// ISSUE | memory strobe cycle, o_gnt pulse
// WAIT  | count down memory latency, capture read data
// RESP  | o_rvalid pulse to the winner
module bb_mem_arbiter #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef BB_ARB_LOCK_EN
  input  logic [1:0]    i_lock,
`endif
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic [1:0]    o_gnt,
  output logic [1:0]    o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t     state;
  logic       last;
  logic       sel;
  logic       lat_we;
  logic [1:0] cnt;
  logic       win;

`ifdef BB_ARB_LOCK_EN
  // high only in the IDLE cycle directly after a RESP
  logic       just_resp;
`endif

  always_comb begin
    win = (i_req == 2'b11) ? ~last : i_req[1];
`ifdef BB_ARB_LOCK_EN
    if (just_resp && i_lock[last] && i_req[last]) win = last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      sel         <= 1'b0;
      lat_we      <= 1'b0;
      cnt         <= 2'd0;
      o_gnt       <= 2'b00;
      o_rvalid    <= 2'b00;
      o_rdata     <= '0;
      o_busy      <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
`ifdef BB_ARB_LOCK_EN
      just_resp   <= 1'b0;
`endif
    end else begin
      o_gnt    <= 2'b00;
      o_rvalid <= 2'b00;
      o_mem_en <= 1'b0;
      o_mem_we <= 1'b0;
`ifdef BB_ARB_LOCK_EN
      just_resp <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_req != 2'b00) begin
            state       <= ISSUE;
            sel         <= win;
            last        <= win;
            lat_we      <= i_we[win];
            o_gnt       <= win ? 2'b10 : 2'b01;
            o_mem_en    <= 1'b1;
            o_mem_we    <= i_we[win];
            o_mem_addr  <= win ? i_addr1 : i_addr0;
            o_mem_wdata <= win ? i_wdata1 : i_wdata0;
            o_busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= LAT_M1;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            // writes complete with zero data so the master sees a clean response
            o_rdata  <= lat_we ? '0 : i_mem_rdata;
            o_rvalid <= sel ? 2'b10 : 2'b01;
            state    <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          o_rdata <= '0;
          o_busy  <= 1'b0;
`ifdef BB_ARB_LOCK_EN
          just_resp <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_mem_arbiter.sv
// Scoreboard bench for bb_mem_arbiter (MEM_LAT=3) with a pipelined memory model.
module tb_bb_mem_arbiter;

  localparam int LAT = 3;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
`ifdef BB_ARB_LOCK_EN
  logic [1:0] lock;
`endif
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       busy, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  bb_mem_arbiter #(.DW(8), .AW(8), .MEM_LAT(LAT)) u_dut (
    .clk         (clk),
    .rst         (rst),
`ifdef BB_ARB_LOCK_EN
    .i_lock      (lock),
`endif
    .i_req       (req),
    .i_we        (we),
    .i_addr0     (addr0),
    .i_addr1     (addr1),
    .i_wdata0    (wdata0),
    .i_wdata1    (wdata1),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory macro: read data appears LAT cycles after the enable cycle
  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic [7:0] pipe  [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {
    logic       m;
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t rsp_q[$];
  int   gnt_cycs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   req_cyc = 0;
  bit   busy_fall_chk = 0;
  exp_t ge, re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      busy_fall_chk = 0;
    end else begin
      if (busy_fall_chk) begin
        chk("busy_fall", 32'(busy), 32'd0);
        busy_fall_chk = 0;
      end
      if (gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexp_gnt", 32'(gnt), 32'd0);
        end else begin
          ge = exp_q.pop_front();
          chk("gnt", 32'(gnt), ge.m ? 32'd2 : 32'd1);
          chk("mem_en", 32'(mem_en), 32'd1);
          chk("mem_we", 32'(mem_we), 32'(ge.w));
          chk("mem_addr", 32'(mem_addr), 32'(ge.addr));
          if (ge.w) chk("mem_wdata", 32'(mem_wdata), 32'(ge.wdata));
          chk("busy_gnt", 32'(busy), 32'd1);
          gnt_cyc = cyc;
          gnt_cycs.push_back(cyc);
          rsp_q.push_back(ge);
        end
      end else begin
        chk("mem_en_idle", 32'(mem_en), 32'd0);
      end
      if (rvalid != 2'b00) begin
        if (rsp_q.size() == 0) begin
          chk("unexp_rvalid", 32'(rvalid), 32'd0);
        end else begin
          re = rsp_q.pop_front();
          chk("rvalid", 32'(rvalid), re.m ? 32'd2 : 32'd1);
          chk("rdata", 32'(rdata), 32'(re.rdata));
          chk("rsp_lat", cyc - gnt_cyc, LAT + 1);
          busy_fall_chk = 1;
        end
      end else begin
        chk("rdata_idle", 32'(rdata), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic m, input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.m = m; e.w = w; e.addr = a; e.wdata = d;
    e.rdata = w ? 8'h00 : model[a];
    if (w) model[a] = d;
    exp_q.push_back(e);
  endtask

  // returns at posedge+1 once at most n grants remain outstanding
  task automatic wait_q(input string tag, input int n);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (exp_q.size() > n && k < 300);
    chk(tag, exp_q.size(), n);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while ((exp_q.size() + rsp_q.size()) != 0 && k < 300);
    chk(tag, exp_q.size() + rsp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt),       32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid),    32'd0);
    chk({tag, "_rdata"},  32'(rdata),     32'd0);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_en"},     32'(mem_en),    32'd0);
    chk({tag, "_we"},     32'(mem_we),    32'd0);
    chk({tag, "_addr"},   32'(mem_addr),  32'd0);
    chk({tag, "_wdata"},  32'(mem_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i * 37 + 11);
      model[i] = 8'(i * 37 + 11);
    end
    mem[8'h10] = 8'h5A;
    model[8'h10] = 8'h5A;
    for (int i = 0; i < LAT; i++) pipe[i] = 8'h00;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
`ifdef BB_ARB_LOCK_EN
    lock = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // continuous tie from reset: strict alternation starting with master 0
    addr0 = 8'h01; addr1 = 8'h02;
    push_exp(1'b0, 1'b0, 8'h01, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    push_exp(1'b0, 1'b0, 8'h01, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    req = 2'b11;
    wait_q("tie_gnts", 0);
    req = 2'b00;
    wait_done("tie_done");
    if (gnt_cycs.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("tie_gap", gnt_cycs[i] - gnt_cycs[i-1], LAT + 3);
    end else begin
      chk("tie_count", gnt_cycs.size(), 4);
    end

    // single read of 0x10 by master 0
    addr0 = 8'h10;
    push_exp(1'b0, 1'b0, 8'h10, 8'h00);
    req_cyc = cyc + 1;
    req = 2'b01;
    wait_q("rd_gnt", 0);
    req = 2'b00;
    chk("gnt_lat", gnt_cyc - req_cyc, 1);
    wait_done("rd_done");

    // write by master 1, then read back by master 0
    addr1 = 8'h20; wdata1 = 8'hC3; we = 2'b10;
    push_exp(1'b1, 1'b1, 8'h20, 8'hC3);
    req = 2'b10;
    wait_q("wr_gnt", 0);
    req = 2'b00; we = 2'b00;
    wait_done("wr_done");
    addr0 = 8'h20;
    push_exp(1'b0, 1'b0, 8'h20, 8'h00);
    req = 2'b01;
    wait_q("rb_gnt", 0);
    req = 2'b00;
    wait_done("rb_done");

`ifdef BB_ARB_LOCK_EN
    // master 1 locks for three accesses, then master 0 gets its turn
    addr0 = 8'h30; addr1 = 8'h31; lock = 2'b10;
    push_exp(1'b1, 1'b0, 8'h31, 8'h00);
    push_exp(1'b1, 1'b0, 8'h31, 8'h00);
    push_exp(1'b1, 1'b0, 8'h31, 8'h00);
    push_exp(1'b0, 1'b0, 8'h30, 8'h00);
    req = 2'b11;
    wait_q("lock_gnts", 1);
    lock = 2'b00;
    wait_q("lock_rel", 0);
    req = 2'b00;
    wait_done("lock_done");
`endif

    // master 0 pulses a request while busy, then withdraws it
    addr1 = 8'h40;
    push_exp(1'b1, 1'b0, 8'h40, 8'h00);
    req = 2'b10;
    wait_q("cx_gnt", 0);
    req = 2'b01;
    @(posedge clk); #1;
    req = 2'b00;
    wait_done("cx_done");
    repeat (12) @(posedge clk);
    #1;

    // reset mid-WAIT discards master 0's access and restores last
    addr0 = 8'h50;
    push_exp(1'b0, 1'b0, 8'h50, 8'h00);
    req = 2'b01;
    wait_q("rw_gnt", 0);
    req = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_q.delete();
    @(negedge clk);
    check_zero("rst_wait");
    repeat (LAT + 4) @(posedge clk);
    #1;
    addr0 = 8'h01; addr1 = 8'h02;
    push_exp(1'b0, 1'b0, 8'h01, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    req = 2'b11;
    wait_q("pr_gnts", 0);
    req = 2'b00;
    wait_done("pr_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
